// File: rtl/glitch_cmd_pkg.sv
// Shared definitions for the glitcher UART command front end.
//   - command byte values accepted in IDLE
//   - single-byte response codes
//   - ID string returned by the hello command
//   - command FSM state encoding
package glitch_cmd_pkg;

    localparam logic [7:0] CMD_SEL   = 8'h63; // 'c'
    localparam logic [7:0] CMD_DELAY = 8'h64; // 'd'
    localparam logic [7:0] CMD_WIDTH = 8'h77; // 'w'
    localparam logic [7:0] CMD_NUM   = 8'h6E; // 'n'
    localparam logic [7:0] CMD_SPACE = 8'h73; // 's'
    localparam logic [7:0] CMD_FIRE  = 8'h74; // 't'
    localparam logic [7:0] CMD_READ  = 8'h72; // 'r'
    localparam logic [7:0] CMD_HELLO = 8'h68; // 'h'

    localparam logic [7:0] RSP_OK   = 8'h4B; // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h45; // 'E'
    localparam logic [7:0] RSP_BUSY = 8'h42; // 'B'
    localparam logic [7:0] RSP_TMO  = 8'h3F; // '?'

    localparam int HELLO_LEN = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARG   = 3'd1,
        S_EXEC  = 3'd2,
        S_FIRE  = 3'd3,
        S_RESP1 = 3'd4,
        S_RB    = 3'd5,
        S_HELLO = 3'd6
    } state_t;

    // "GLv2\n"
    function automatic logic [7:0] hello_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hello_byte = 8'h47;
            3'd1:    hello_byte = 8'h4C;
            3'd2:    hello_byte = 8'h76;
            3'd3:    hello_byte = 8'h32;
            default: hello_byte = 8'h0A;
        endcase
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous byte FIFO holding response bytes on their way to uart_tx.
// Ports: clk, rst (async, active high), push/din (write, ignored when
// full), pop (read, ignored when empty), dout (head of queue, valid while
// !empty), full, empty.
module resp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;

    // Extra pointer bit distinguishes full from empty when indexes match.
    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign dout  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push && !full) r_wp <= r_wp + 1'b1;
            if (pop && !empty) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Ports: clk, rst, i_rx (serial line), o_data (last
// received byte), o_valid (one-cycle strobe per byte with a good stop bit).
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;

    logic [1:0]  r_sync;
    logic [1:0]  r_phase;
    logic [15:0] r_clk;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_phase <= 2'd0;
            r_clk   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rx};
            o_valid <= 1'b0;
            case (r_phase)
                2'd0: if (!w_rx) begin
                    r_phase <= 2'd1;
                    r_clk   <= '0;
                end
                // Re-check the start bit at mid-bit to reject line glitches.
                2'd1: if (r_clk == 16'(CPB / 2 - 1)) begin
                    r_clk   <= '0;
                    r_bit   <= '0;
                    r_phase <= w_rx ? 2'd0 : 2'd2;
                end else r_clk <= r_clk + 1'b1;
                2'd2: if (r_clk == 16'(CPB - 1)) begin
                    r_clk   <= '0;
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_phase <= 2'd3;
                end else r_clk <= r_clk + 1'b1;
                default: if (r_clk == 16'(CPB - 1)) begin
                    r_clk   <= '0;
                    r_phase <= 2'd0;
                    if (w_rx) begin
                        o_data  <= r_shift;
                        o_valid <= 1'b1;
                    end
                end else r_clk <= r_clk + 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Ports: clk, rst, i_tx_en (start strobe, ignored
// while busy), i_data (byte captured on i_tx_en), o_tx (serial line,
// idle high), o_busy (high from the cycle after i_tx_en until stop bit ends).
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_en,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;

    logic [9:0]  r_shift;
    logic [3:0]  r_bits;
    logic [15:0] r_clk;

    assign o_busy = (r_bits != 4'd0);
    assign o_tx   = r_shift[0];

    // Shift in ones so the line rests high once the frame is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '1;
            r_bits  <= '0;
            r_clk   <= '0;
        end else if (i_tx_en && !o_busy) begin
            r_shift <= {1'b1, i_data, 1'b0};
            r_bits  <= 4'd10;
            r_clk   <= '0;
        end else if (o_busy) begin
            if (r_clk == 16'(CPB - 1)) begin
                r_clk   <= '0;
                r_shift <= {1'b1, r_shift[9:1]};
                r_bits  <= r_bits - 1'b1;
            end else begin
                r_clk <= r_clk + 1'b1;
            end
        end
    end

endmodule

// File: rtl/glitch_cmd_handler.sv
// UART command front end for the glitcher: decodes host commands into
// per-channel pulse parameters and answers over uart_tx.
// Ports: clk, rst (async, active high); uart_rx_i / uart_tx_o serial pins;
// pulse_busy_i per-channel busy; delay_o, width_o, num_pulses_o,
// pulse_spacing_o packed per-channel parameters (channel 0 in LSBs);
// pulse_en_o one-cycle fire strobes; dbg_state_o current command FSM state.
//
// Response path handshake: the FSM pushes one byte per cycle only while the
// FIFO is not full (push and !full), and the drain pops the head only while
// the FIFO is not empty and the transmitter is idle (pop and !empty).
module glitch_cmd_handler
    import glitch_cmd_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int NUM_CH         = 2,
    parameter int DELAY_BYTES    = 2,
    parameter int SPACING_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 10,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              uart_rx_i,
    output logic                              uart_tx_o,
    input  logic [NUM_CH-1:0]                 pulse_busy_i,
    output logic [NUM_CH*8*DELAY_BYTES-1:0]   delay_o,
    output logic [NUM_CH*8-1:0]               width_o,
    output logic [NUM_CH*8-1:0]               num_pulses_o,
    output logic [NUM_CH*8*SPACING_BYTES-1:0] pulse_spacing_o,
    output logic [NUM_CH-1:0]                 pulse_en_o,
    output logic [2:0]                        dbg_state_o
);
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int STG_W  = 8 * ((DELAY_BYTES > SPACING_BYTES) ? DELAY_BYTES : SPACING_BYTES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RB_LEN = DELAY_BYTES + SPACING_BYTES + 2;
    localparam int DW     = 8 * DELAY_BYTES;
    localparam int SW     = 8 * SPACING_BYTES;

    logic [7:0]       w_rx_data;
    logic             w_rx_valid;
    logic             w_tx_busy;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_dout;
    logic             w_pop;
    logic             w_push;
    logic [7:0]       w_push_data;
    logic [NUM_CH-1:0] w_pulse_en;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_cmd;
    logic [2:0]       r_cnt;
    logic [STG_W-1:0] r_stage;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_rsp;
    logic [3:0]       r_idx;
    logic [SEL_W-1:0] r_sel;
    logic [1:0]       r_guard;

    logic [DW-1:0]    r_delay   [NUM_CH];
    logic [7:0]       r_width   [NUM_CH];
    logic [7:0]       r_num     [NUM_CH];
    logic [SW-1:0]    r_spacing [NUM_CH];

    logic [NUM_CH-1:0] w_fire_v;
    logic              w_fire_blocked;
    logic              w_sel_ok;
    logic              w_timeout;
    logic [7:0]        w_rb_byte;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(clk), .rst(rst), .i_rx(uart_rx_i), .o_data(w_rx_data), .o_valid(w_rx_valid)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(clk), .rst(rst), .i_tx_en(w_pop), .i_data(w_fifo_dout),
        .o_tx(uart_tx_o), .o_busy(w_tx_busy)
    );

    resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(w_push), .din(w_push_data), .pop(w_pop),
        .dout(w_fifo_dout), .full(w_full), .empty(w_empty)
    );

    assign w_fire_v       = r_stage[NUM_CH-1:0];
    assign w_fire_blocked = |(w_fire_v & pulse_busy_i);
    assign w_sel_ok       = (r_stage[7:0] < 8'(NUM_CH));
    assign w_timeout      = (r_state == S_ARG) && !w_rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign dbg_state_o    = r_state;
    assign pulse_en_o     = w_pulse_en;

    // Readback order: delay MSB..LSB, width, num_pulses, spacing MSB..LSB.
    always_comb begin
        w_rb_byte = 8'h00;
        for (int k = 0; k < DELAY_BYTES; k++)
            if (r_idx == 4'(DELAY_BYTES - 1 - k)) w_rb_byte = r_delay[r_sel][8*k +: 8];
        if (r_idx == 4'(DELAY_BYTES))     w_rb_byte = r_width[r_sel];
        if (r_idx == 4'(DELAY_BYTES + 1)) w_rb_byte = r_num[r_sel];
        for (int k = 0; k < SPACING_BYTES; k++)
            if (r_idx == 4'(DELAY_BYTES + 2 + SPACING_BYTES - 1 - k)) w_rb_byte = r_spacing[r_sel][8*k +: 8];
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            delay_o[c*DW +: DW]         = r_delay[c];
            width_o[c*8 +: 8]           = r_width[c];
            num_pulses_o[c*8 +: 8]      = r_num[c];
            pulse_spacing_o[c*SW +: SW] = r_spacing[c];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_rx_valid) begin
                case (w_rx_data)
                    CMD_SEL, CMD_DELAY, CMD_WIDTH, CMD_NUM, CMD_SPACE, CMD_FIRE: w_next = S_ARG;
                    CMD_READ:  w_next = S_RB;
                    CMD_HELLO: w_next = S_HELLO;
                    default:   w_next = S_RESP1;
                endcase
            end
            S_ARG: begin
                if (w_rx_valid && r_cnt == 3'd1) w_next = (r_cmd == CMD_FIRE) ? S_FIRE : S_EXEC;
                else if (w_timeout)              w_next = S_RESP1;
            end
            S_EXEC, S_FIRE: w_next = S_RESP1;
            S_RESP1: if (!w_full) w_next = S_IDLE;
            S_RB:    if (!w_full && r_idx == 4'(RB_LEN - 1))    w_next = S_IDLE;
            S_HELLO: if (!w_full && r_idx == 4'(HELLO_LEN - 1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The fire strobe is decoded from FIRE directly, so it lands exactly one
    // cycle after the mask byte and checks busy in that same cycle.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = r_rsp;
        w_pulse_en  = '0;
        case (r_state)
            S_FIRE:  if (!w_fire_blocked) w_pulse_en = w_fire_v;
            S_RESP1: w_push = !w_full;
            S_RB: begin
                w_push      = !w_full;
                w_push_data = w_rb_byte;
            end
            S_HELLO: begin
                w_push      = !w_full;
                w_push_data = hello_byte(r_idx[2:0]);
            end
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd   <= '0;
            r_cnt   <= '0;
            r_stage <= '0;
            r_tmo   <= '0;
            r_rsp   <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_delay[c]   <= '0;
                r_width[c]   <= '0;
                r_num[c]     <= '0;
                r_spacing[c] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_rx_valid) begin
                    r_cmd   <= w_rx_data;
                    r_rsp   <= w_rx_data;          // echo for unknown bytes
                    r_stage <= '0;
                    r_tmo   <= '0;
                    r_idx   <= '0;
                    if (w_rx_data == CMD_DELAY)      r_cnt <= 3'(DELAY_BYTES);
                    else if (w_rx_data == CMD_SPACE) r_cnt <= 3'(SPACING_BYTES);
                    else                             r_cnt <= 3'd1;
                end
                S_ARG: begin
                    if (w_rx_valid) begin
                        r_stage <= (r_stage << 8) | STG_W'(w_rx_data);
                        r_cnt   <= r_cnt - 1'b1;
                        r_tmo   <= '0;
                    end else if (w_timeout) begin
                        r_rsp <= RSP_TMO;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_rsp <= RSP_OK;
                    case (r_cmd)
                        CMD_SEL: begin
                            if (w_sel_ok) r_sel <= r_stage[SEL_W-1:0];
                            else          r_rsp <= RSP_ERR;
                        end
                        CMD_DELAY: r_delay[r_sel]   <= r_stage[DW-1:0];
                        CMD_WIDTH: r_width[r_sel]   <= r_stage[7:0];
                        CMD_NUM:   r_num[r_sel]     <= r_stage[7:0];
                        CMD_SPACE: r_spacing[r_sel] <= r_stage[SW-1:0];
                        default: ;
                    endcase
                end
                S_FIRE: r_rsp <= w_fire_blocked ? RSP_BUSY : RSP_OK;
                S_RB, S_HELLO: if (!w_full) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Drain: after a pop, wait until the transmitter reports busy (or two
    // cycles pass) so its busy latency can never let a second pop slip in.
    assign w_pop = !w_empty && !w_tx_busy && (r_guard == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_guard <= 2'd0;
        else if (w_pop)           r_guard <= 2'd2;
        else if (r_guard != 2'd0) r_guard <= w_tx_busy ? 2'd0 : r_guard - 1'b1;
    end

endmodule

// File: tb/tb_glitch_cmd_handler.sv
// Directed bench for glitch_cmd_handler: drives serial bytes into uart_rx_i,
// decodes uart_tx_o back into bytes and checks responses and parameter
// outputs against hand-computed values.
module tb_glitch_cmd_handler;

    localparam int CPB      = 8;      // 8 MHz / 1 Mbaud
    localparam int TIMEOUT  = 300;
    localparam int WAIT_MAX = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic [1:0]  pulse_busy_i = 2'b00;
    logic [31:0] delay_o;
    logic [15:0] width_o;
    logic [15:0] num_pulses_o;
    logic [31:0] pulse_spacing_o;
    logic [1:0]  pulse_en_o;
    logic [2:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic       mon_rst_seen = 1'b0;
    int         tx_fall_cnt  = 0;
    int         pulse_cnt    = 0;
    logic [1:0] pulse_val    = 2'b00;

    glitch_cmd_handler #(
        .CLK_FREQ(8_000_000), .BAUD_RATE(1_000_000), .NUM_CH(2),
        .DELAY_BYTES(2), .SPACING_BYTES(2), .TIMEOUT_CYCLES(TIMEOUT), .RESP_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .pulse_busy_i(pulse_busy_i), .delay_o(delay_o), .width_o(width_o),
        .num_pulses_o(num_pulses_o), .pulse_spacing_o(pulse_spacing_o),
        .pulse_en_o(pulse_en_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- monitors ----------------
    always @(posedge rst) mon_rst_seen = 1'b1;
    always @(negedge uart_tx_o) tx_fall_cnt++;
    always @(negedge clk) if (pulse_en_o != 2'b00) begin
        pulse_cnt++;
        pulse_val = pulse_en_o;
    end

    // Serial decoder: samples each bit near its centre; frames cut by reset
    // or lacking a stop bit are discarded.
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop;
        forever begin
            @(negedge uart_tx_o);
            mon_rst_seen = 1'b0;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx_o;
            end
            repeat (CPB) @(negedge clk);
            stop = uart_tx_o;
            if (stop && !mon_rst_seen) rx_q.push_back(b);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        uart_rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx_i = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int waited;
        logic [7:0] got;
        waited = 0;
        while (rx_q.size() == 0 && waited < WAIT_MAX) begin
            @(negedge clk);
            waited++;
        end
        if (rx_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s no tx byte within %0d cycles, expected %h", tag, WAIT_MAX, exp);
        end else begin
            got = rx_q.pop_front();
            check_eq(tag, 64'(got), 64'(exp));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #800_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        #3 rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("reset tx idle",   64'(uart_tx_o),       64'd1);
        check_eq("reset delay",     64'(delay_o),         64'd0);
        check_eq("reset width",     64'(width_o),         64'd0);
        check_eq("reset num",       64'(num_pulses_o),    64'd0);
        check_eq("reset spacing",   64'(pulse_spacing_o), 64'd0);
        check_eq("reset pulse_en",  64'(pulse_en_o),      64'd0);
        check_eq("reset state",     64'(dbg_state_o),     64'd0);

        // Select channel 1, write its delay; field changes only on last byte.
        send_byte("c"); send_byte(8'h01);
        expect_tx("sel ch1 ack", 8'h4B);
        send_byte("d"); send_byte(8'h12);
        check_eq("delay mid write", 64'(delay_o), 64'h0000_0000);
        send_byte(8'h34);
        check_eq("delay ch1 final", 64'(delay_o), 64'h1234_0000);
        expect_tx("delay ack", 8'h4B);

        // Inter-byte timeout abandons the write.
        send_byte("d"); send_byte(8'hAB);
        expect_tx("timeout resp", 8'h3F);
        check_eq("delay after timeout", 64'(delay_o), 64'h1234_0000);
        send_byte("w"); send_byte(8'h05);
        expect_tx("width ack", 8'h4B);
        check_eq("width ch1", 64'(width_o), 64'h0500);

        // Fill channel 0 and read it back through the 4-deep FIFO.
        send_byte("c"); send_byte(8'h00); expect_tx("sel ch0 ack", 8'h4B);
        send_byte("d"); send_byte(8'h01); send_byte(8'h02); expect_tx("d0 ack", 8'h4B);
        send_byte("w"); send_byte(8'h03); expect_tx("w0 ack", 8'h4B);
        send_byte("n"); send_byte(8'h04); expect_tx("n0 ack", 8'h4B);
        send_byte("s"); send_byte(8'h05); send_byte(8'h06); expect_tx("s0 ack", 8'h4B);
        check_eq("delay both",   64'(delay_o),         64'h1234_0102);
        check_eq("width both",   64'(width_o),         64'h0503);
        check_eq("num both",     64'(num_pulses_o),    64'h0004);
        check_eq("spacing both", 64'(pulse_spacing_o), 64'h0000_0506);
        send_byte("r");
        expect_tx("rb delay hi", 8'h01);
        expect_tx("rb delay lo", 8'h02);
        expect_tx("rb width",    8'h03);
        expect_tx("rb num",      8'h04);
        expect_tx("rb space hi", 8'h05);
        expect_tx("rb space lo", 8'h06);

        // Fire strobes and busy interlock.
        pulse_cnt = 0;
        send_byte("t"); send_byte(8'h03);
        expect_tx("fire ack", 8'h4B);
        check_eq("fire strobe count", 64'(pulse_cnt), 64'd1);
        check_eq("fire strobe value", 64'(pulse_val), 64'd3);
        pulse_busy_i = 2'b10;
        pulse_cnt = 0;
        send_byte("t"); send_byte(8'h03);
        expect_tx("fire busy resp", 8'h42);
        check_eq("busy no strobe", 64'(pulse_cnt), 64'd0);
        pulse_cnt = 0;
        send_byte("t"); send_byte(8'h05);   // bit 2 is beyond NUM_CH
        expect_tx("fire masked ack", 8'h4B);
        check_eq("masked strobe count", 64'(pulse_cnt), 64'd1);
        check_eq("masked strobe value", 64'(pulse_val), 64'd1);
        pulse_cnt = 0;
        send_byte("t"); send_byte(8'h00);
        expect_tx("fire empty ack", 8'h4B);
        check_eq("empty no strobe", 64'(pulse_cnt), 64'd0);
        pulse_busy_i = 2'b00;

        // Bad channel select keeps channel 0.
        send_byte("c"); send_byte(8'h07); expect_tx("sel 7 err", 8'h45);
        send_byte("c"); send_byte(8'h02); expect_tx("sel 2 err", 8'h45);
        send_byte("w"); send_byte(8'h09); expect_tx("w after err ack", 8'h4B);
        check_eq("width sel kept", 64'(width_o), 64'h0509);

        // Echo and ID string.
        send_byte("x"); expect_tx("echo x", 8'h78);
        send_byte("h");
        expect_tx("hello G",  8'h47);
        expect_tx("hello L",  8'h4C);
        expect_tx("hello v",  8'h76);
        expect_tx("hello 2",  8'h32);
        expect_tx("hello nl", 8'h0A);

        // Reset part-way through a readback.
        send_byte("r");
        expect_tx("rb before rst", 8'h01);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_fall_cnt = 0;
        check_eq("post rst tx idle", 64'(uart_tx_o),       64'd1);
        check_eq("post rst delay",   64'(delay_o),         64'd0);
        check_eq("post rst width",   64'(width_o),         64'd0);
        check_eq("post rst num",     64'(num_pulses_o),    64'd0);
        check_eq("post rst spacing", 64'(pulse_spacing_o), 64'd0);
        check_eq("post rst state",   64'(dbg_state_o),     64'd0);
        repeat (400) @(negedge clk);
        check_eq("post rst no tx",   64'(tx_fall_cnt),     64'd0);
        check_eq("post rst no bytes", 64'(rx_q.size()),    64'd0);
        send_byte("x");
        expect_tx("post rst echo", 8'h78);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
